// File: rtl/scoreboard_regfile_pkg.sv
// Shared types and constants for the scoreboarded integer register file.
package scoreboard_regfile_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RF_INIT  = 2'd0,
        RF_IDLE  = 2'd1,
        RF_CLEAR = 2'd2
    } regfile_state_e;

endpackage

// File: rtl/scoreboard_regfile_clear_seq.sv
// Clear sequencer: walks every register index once after reset or on a clear
// request, then reports the file ready for normal use.
module regfile_clear_seq
    import scoreboard_regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_idx_o,
    output logic          clr_start_o,
    output logic          ready_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    regfile_state_e state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;

    // Next state: INIT and CLEAR walk cnt up to the last index, IDLE waits for a clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_INIT, RF_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RF_IDLE: begin
                if (clear_req_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset restarts the zeroing walk from index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o     = (state_q == RF_IDLE);
    assign clr_we_o    = !ready_o;
    assign clr_idx_o   = cnt_q;
    assign clr_start_o = ready_o && clear_req_i;

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port integer register file with two write lanes, write-to-read bypass,
// per-register pending bits and a hardware clear sequencer.
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 1 << REG_AW,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NRP*$clog2(NREGS)-1:0]      rs_sel,
    output logic [NRP*XLEN-1:0]               rs_out,
    output logic [NRP-1:0]                    rs_pend,
    input  logic [1:0]                        wr_en,
    input  logic [2*$clog2(NREGS)-1:0]        wr_sel,
    input  logic [2*XLEN-1:0]                 wr_data,
    input  logic                              claim_en,
    input  logic [$clog2(NREGS)-1:0]          claim_sel,
    input  logic                              clear_req,
    output logic                              ready
);

    localparam int AW = $clog2(NREGS);
    localparam bit R0_HARD = (ZERO_R0 != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    logic             clr_we;
    logic [AW-1:0]    clr_idx;
    logic             clr_start;

    logic [AW-1:0]    wsel  [2];
    logic [XLEN-1:0]  wdat  [2];
    logic             wkeep [2];
    logic             claim_keep;

    logic [AW-1:0]    rsel  [NRP];

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req_i (clear_req),
        .clr_we_o    (clr_we),
        .clr_idx_o   (clr_idx),
        .clr_start_o (clr_start),
        .ready_o     (ready)
    );

    // Unpack write lanes and qualify them: only in IDLE, never to a hardwired r0.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            wsel[i]  = wr_sel[i*AW +: AW];
            wdat[i]  = wr_data[i*XLEN +: XLEN];
            wkeep[i] = ready && wr_en[i] && !(R0_HARD && (wsel[i] == '0));
        end
        claim_keep = ready && claim_en && !(R0_HARD && (claim_sel == '0));
    end

    // Data array (no reset): the sequencer zeroes it; lane 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else begin
            if (wkeep[0]) regs_q[wsel[0]] <= wdat[0];
            if (wkeep[1]) regs_q[wsel[1]] <= wdat[1];
        end
    end

    // Pending next state: clear entry wipes all, writes retire, a same-cycle claim wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_start) begin
            pend_d = '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (wkeep[i]) pend_d[wsel[i]] = 1'b0;
            end
            if (claim_keep) pend_d[claim_sel] = 1'b1;
        end
    end

    // Pending bits register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // Read ports: lane 1 bypass over lane 0 over array; forced zero while clearing or on r0.
    always_comb begin
        rs_out  = '0;
        rs_pend = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            rsel[p] = rs_sel[p*AW +: AW];
            rs_out[p*XLEN +: XLEN] = regs_q[rsel[p]];
            rs_pend[p]             = pend_q[rsel[p]];
            if (wkeep[0] && (wsel[0] == rsel[p])) begin
                rs_out[p*XLEN +: XLEN] = wdat[0];
                rs_pend[p]             = 1'b0;
            end
            if (wkeep[1] && (wsel[1] == rsel[p])) begin
                rs_out[p*XLEN +: XLEN] = wdat[1];
                rs_pend[p]             = 1'b0;
            end
            if (!ready || (R0_HARD && (rsel[p] == '0))) begin
                rs_out[p*XLEN +: XLEN] = '0;
                rs_pend[p]             = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomised bench for scoreboard_regfile against a behavioural model of the file.
module tb_scoreboard_regfile;
    import scoreboard_regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NRP*AW-1:0]    rs_sel;
    logic [NRP*XLEN-1:0]  rs_out;
    logic [NRP-1:0]       rs_pend;
    logic [1:0]           wr_en;
    logic [2*AW-1:0]      wr_sel;
    logic [2*XLEN-1:0]    wr_data;
    logic                 claim_en;
    reg_idx_t             claim_sel;
    logic                 clear_req;
    logic                 ready;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents, pending flags, cycles left until usable.
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_pend [NREGS];
    int              m_busy;

    scoreboard_regfile #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .NRP     (NRP),
        .ZERO_R0 (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_sel    (rs_sel),
        .rs_out    (rs_out),
        .rs_pend   (rs_pend),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .claim_en  (claim_en),
        .claim_sel (claim_sel),
        .clear_req (clear_req),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_sel = '0; wr_data = '0;
        claim_en = 1'b0; claim_sel = '0; clear_req = 1'b0; rs_sel = '0;
    endtask

    task automatic set_rs(input int p, input int r);
        rs_sel[p*AW +: AW] = AW'(r);
    endtask

    task automatic set_wr(input int lane, input int r, input logic [31:0] d);
        wr_en[lane] = 1'b1;
        wr_sel[lane*AW +: AW] = AW'(r);
        wr_data[lane*XLEN +: XLEN] = d;
    endtask

    function automatic logic [31:0] port_data(input int p);
        return rs_out[p*XLEN +: XLEN];
    endfunction

    // Expected read result from the file's rules: newest same-cycle write seen first.
    task automatic model_read(input int r, output logic [31:0] d, output logic pd);
        d = m_regs[r]; pd = m_pend[r];
        if (m_busy != 0 || r == 0) begin
            d = '0; pd = 1'b0;
        end else if (wr_en[1] && int'(wr_sel[AW +: AW]) == r) begin
            d = wr_data[XLEN +: XLEN]; pd = 1'b0;
        end else if (wr_en[0] && int'(wr_sel[0 +: AW]) == r) begin
            d = wr_data[0 +: XLEN]; pd = 1'b0;
        end
    endtask

    task automatic check_ports(input string tag);
        logic [31:0] d;
        logic        pd;
        #1;
        chk({tag, "_ready"}, 32'(ready), 32'(m_busy == 0));
        for (int p = 0; p < NRP; p++) begin
            model_read(int'(rs_sel[p*AW +: AW]), d, pd);
            chk($sformatf("%s_data%0d", tag, p), port_data(p), d);
            chk($sformatf("%s_pend%0d", tag, p), 32'(rs_pend[p]), 32'(pd));
        end
    endtask

    // One clock edge; the model applies the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (m_busy != 0) begin
            m_busy--;
        end else if (clear_req) begin
            m_busy = NREGS;
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0; m_pend[r] = 1'b0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (wr_en[l] && wr_sel[l*AW +: AW] != '0) begin
                    m_regs[wr_sel[l*AW +: AW]] = wr_data[l*XLEN +: XLEN];
                    m_pend[wr_sel[l*AW +: AW]] = 1'b0;
                end
            end
            if (claim_en && claim_sel != '0) m_pend[claim_sel] = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready_low", 32'(ready), 32'd0);
        chk("rst_pend0", 32'(rs_pend[0]), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_busy = NREGS;
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0; m_pend[r] = 1'b0;
        end
    endtask

    function automatic int rnd_idx();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1))
                                           : int'($urandom_range(0, 7));
    endfunction

    task automatic random_inputs(input int clear_odds);
        idle_inputs();
        for (int l = 0; l < 2; l++)
            if ($urandom_range(0, 1) == 1) set_wr(l, rnd_idx(), $urandom());
        claim_en  = ($urandom_range(0, 2) == 0);
        claim_sel = reg_idx_t'(rnd_idx());
        clear_req = (clear_odds > 0) && ($urandom_range(1, clear_odds) == 1);
        for (int p = 0; p < NRP; p++) set_rs(p, rnd_idx());
    endtask

    task automatic readback_all(input string tag);
        idle_inputs();
        for (int r = 0; r < NREGS; r++) begin
            set_rs(0, r);
            set_rs(1, NREGS - 1 - r);
            check_ports(tag);
        end
    endtask

    initial begin
        idle_inputs();

        // 1: reset, ready only after NREGS edges, everything reads zero
        do_reset();
        for (int i = 0; i < NREGS; i++) begin
            #1 chk("init_ready_low", 32'(ready), 32'd0);
            tick();
        end
        chk("init_ready_high", 32'(ready), 32'd1);
        readback_all("init_zero");

        // 2: lane 0 write with same-cycle bypass, then array value
        idle_inputs(); set_wr(0, 5, 32'hDEADBEEF); set_rs(0, 5);
        #1 chk("byp0_data", port_data(0), 32'hDEADBEEF);
        check_ports("byp0");
        tick();
        idle_inputs(); set_rs(0, 5);
        #1 chk("arr_r5", port_data(0), 32'hDEADBEEF);

        // 3: both lanes hit r7, lane 1 wins
        idle_inputs(); set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); set_rs(1, 7);
        #1 chk("byp1_data", port_data(1), 32'h2222);
        tick();
        idle_inputs(); set_rs(1, 7);
        #1 chk("arr_r7", port_data(1), 32'h2222);

        // 4: claim / write / claim+write on r9
        idle_inputs(); claim_en = 1'b1; claim_sel = 5'd9; set_rs(0, 9);
        tick();
        idle_inputs(); set_rs(0, 9);
        #1 chk("claim_pend", 32'(rs_pend[0]), 32'd1);
        set_wr(0, 9, 32'h42);
        #1 chk("wr_byp_pend", 32'(rs_pend[0]), 32'd0);
        tick();
        idle_inputs(); set_rs(0, 9);
        #1 chk("wr_clr_pend", 32'(rs_pend[0]), 32'd0);
        set_wr(1, 9, 32'h42); claim_en = 1'b1; claim_sel = 5'd9;
        tick();
        idle_inputs(); set_rs(0, 9);
        #1 chk("cw_data", port_data(0), 32'h42);
        chk("cw_pend", 32'(rs_pend[0]), 32'd1);

        // 5: r0 is hardwired
        idle_inputs(); set_wr(0, 0, 32'hFFFF_FFFF); set_rs(0, 0);
        claim_en = 1'b1; claim_sel = '0;
        #1 chk("r0_byp", port_data(0), 32'd0);
        tick();
        idle_inputs(); set_rs(0, 0);
        #1 chk("r0_data", port_data(0), 32'd0);
        chk("r0_pend", 32'(rs_pend[0]), 32'd0);

        // 6: fill, start a clear, reset at cnt=10, then full re-init
        for (int r = 1; r < NREGS; r++) begin
            idle_inputs(); set_wr(r % 2, r, 32'h0101_0101 * r);
            claim_en = 1'b1; claim_sel = reg_idx_t'(NREGS - r);
            tick();
        end
        readback_all("filled");
        idle_inputs(); clear_req = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            random_inputs(2);
            check_ports("clearing");
            tick();
        end
        do_reset();
        for (int i = 0; i < NREGS; i++) begin
            random_inputs(3);
            check_ports("reinit");
            tick();
        end
        readback_all("after_clear");

        // Randomised traffic with occasional clears
        for (int i = 0; i < 3000; i++) begin
            random_inputs(150);
            check_ports("rand");
            tick();
        end
        while (m_busy != 0) begin
            idle_inputs();
            tick();
        end
        readback_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
